// File: rtl/double_unit_arbiter.sv
// Round-robin sharing of one fixed-latency double-precision unit among N requesters.
// Latency: in_a_ack one cycle after the issue edge; out_z_stb from issue edge + LATENCY.
// Backpressure: an unacked result holds its slot and blocks that requester from reissue.
module double_unit_arbiter #(
    parameter int N       = 4,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [64*N-1:0] in_a,
    input  logic [N-1:0]    in_a_stb,
    output logic [N-1:0]    in_a_ack,
    output logic [64*N-1:0] out_z,
    output logic [N-1:0]    out_z_stb,
    input  logic [N-1:0]    out_z_ack,
    output logic [63:0]     unit_a,
    input  logic [63:0]     unit_z
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic          vld;
        logic [PW-1:0] idx;
    } tag_t;

    logic [N-1:0]  busy;
    logic [PW-1:0] ptr;
    tag_t          tag_q [LATENCY];
    logic [N-1:0]  elig;
    logic          gnt_vld;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] ptr_nxt;
    logic [PW:0]   rr_sum;
    tag_t          cap;

    assign elig    = in_a_stb & ~busy;
    assign cap     = tag_q[LATENCY-1];
    assign ptr_nxt = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;

    // Search from ptr upwards, wrapping; the first eligible index wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        for (int o = 0; o < N; o++) begin
            rr_sum = {1'b0, ptr} + (PW+1)'(o);
            if (rr_sum >= (PW+1)'(N)) begin
                rr_sum = rr_sum - (PW+1)'(N);
            end
            if (!gnt_vld && elig[rr_sum[PW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_sum[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_a_ack  <= '0;
            out_z     <= '0;
            out_z_stb <= '0;
            unit_a    <= '0;
            busy      <= '0;
            ptr       <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            in_a_ack <= '0;
            tag_q[0] <= tag_t'{vld: gnt_vld, idx: gnt_idx};
            for (int s = 1; s < LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end

            for (int i = 0; i < N; i++) begin
                if (out_z_stb[i] && out_z_ack[i]) begin
                    out_z_stb[i] <= 1'b0;
                    busy[i]      <= 1'b0;
                end
            end

            // unit_a deliberately holds its last operand on idle cycles.
            if (gnt_vld) begin
                unit_a                        <= in_a[{gnt_idx, 6'd0} +: 64];
                in_a_ack[gnt_idx]             <= 1'b1;
                busy[gnt_idx]                 <= 1'b1;
                ptr                           <= ptr_nxt;
            end

            if (cap.vld) begin
                out_z[{cap.idx, 6'd0} +: 64] <= unit_z;
                out_z_stb[cap.idx]           <= 1'b1;
            end
        end
    end

    // busy blocks reissue, so a returning result always finds its slot empty.
    cap_into_free_slot: assert property (@(posedge clk) disable iff (rst)
        cap.vld |-> !out_z_stb[cap.idx]);

    ack_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(in_a_ack));

endmodule
